// File: rtl/servo_sequencer.sv
// Five-channel duty-code sequencer: holds a target per channel and slews each
// duty_cycle output toward it by one code per STEP_TICKS clocks.
module servo_sequencer #(
  parameter int STEP_TICKS = 100000,
  parameter int DUTY_MAX   = 100,
  parameter int RESET_DUTY = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_mode,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_ch,
  input  logic [6:0] cmd_target,
  output logic [6:0] duty_cycle_1,
  output logic [6:0] duty_cycle_2,
  output logic [6:0] duty_cycle_3,
  output logic [6:0] duty_cycle_4,
  output logic [6:0] duty_cycle_5,
  output logic [4:0] ch_busy,
  output logic       all_idle,
  output logic       cmd_err
);

  localparam int              CW       = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(STEP_TICKS - 1);
  localparam logic [6:0]      DMAX     = 7'(DUTY_MAX);
  localparam logic [6:0]      RST_DUTY = 7'(RESET_DUTY);

  logic [CW-1:0] cnt;
  logic [6:0]    cur [5];
  logic [6:0]    tgt [5];
  logic          step;
  logic          accept;
  logic          illegal;
  logic [6:0]    tgt_val;
  logic [4:0]    wr_mask;

  assign step      = (cnt == CNT_LAST);
  assign cmd_ready = ~sync_mode | all_idle;
  assign accept    = cmd_valid & cmd_ready;
  assign tgt_val   = (cmd_target > DMAX) ? DMAX : cmd_target;
  assign illegal   = accept & ((cmd_ch == 3'd5) | (cmd_ch == 3'd6));

  always_comb begin
    wr_mask = '0;
    if (accept) begin
      if (cmd_ch == 3'd7)
        wr_mask = '1;
      else if (cmd_ch < 3'd5)
        wr_mask = 5'b00001 << cmd_ch;
    end
  end

  always_comb begin
    ch_busy = '0;
    for (int unsigned i = 0; i < 5; i++)
      ch_busy[i] = (cur[i] != tgt[i]);
  end

  assign all_idle = ~|ch_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (step)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cmd_err <= 1'b0;
    else
      cmd_err <= illegal;
  end

  // A channel whose target is being written this edge skips the step so the
  // move always starts from the new target's first eligible step edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 5; i++) begin
        cur[i] <= RST_DUTY;
        tgt[i] <= RST_DUTY;
      end
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (wr_mask[i])
          tgt[i] <= tgt_val;
        else if (step) begin
          if (cur[i] < tgt[i])
            cur[i] <= cur[i] + 7'd1;
          else if (cur[i] > tgt[i])
            cur[i] <= cur[i] - 7'd1;
        end
      end
    end
  end

  assign duty_cycle_1 = cur[0];
  assign duty_cycle_2 = cur[1];
  assign duty_cycle_3 = cur[2];
  assign duty_cycle_4 = cur[3];
  assign duty_cycle_5 = cur[4];

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer with STEP_TICKS=4: ramps, clamp,
// sync backpressure, retarget, illegal channel and async reset.
module tb_servo_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync_mode;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_ch;
  logic [6:0] cmd_target;
  logic [6:0] duty_cycle_1, duty_cycle_2, duty_cycle_3, duty_cycle_4, duty_cycle_5;
  logic [4:0] ch_busy;
  logic       all_idle;
  logic       cmd_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  servo_sequencer #(
    .STEP_TICKS(4),
    .DUTY_MAX  (100),
    .RESET_DUTY(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sync_mode   (sync_mode),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_target  (cmd_target),
    .duty_cycle_1(duty_cycle_1),
    .duty_cycle_2(duty_cycle_2),
    .duty_cycle_3(duty_cycle_3),
    .duty_cycle_4(duty_cycle_4),
    .duty_cycle_5(duty_cycle_5),
    .ch_busy     (ch_busy),
    .all_idle    (all_idle),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one rising edge, return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick_n(2);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    logic [6:0] seq [8];
    seq = '{7'd51, 7'd52, 7'd53, 7'd54, 7'd55, 7'd54, 7'd53, 7'd52};

    sync_mode  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ch     = 3'd0;
    cmd_target = 7'd0;
    @(negedge clk);
    do_reset();

    chk("rst_duty1", duty_cycle_1, 50);
    chk("rst_duty5", duty_cycle_5, 50);
    chk("rst_busy", ch_busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_idle", all_idle, 1);
    chk("rst_err", cmd_err, 0);

    // Single ramp: accepted on edge 1; steps on edges 4, 8, 12.
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_target = 7'd53;
    tick();
    cmd_valid = 1'b0;
    chk("ramp_busy_after_accept", ch_busy, 5'b00001);
    for (int e = 2; e <= 12; e++) begin
      tick();
      chk("ramp_duty1", duty_cycle_1, 50 + e / 4);
      chk("ramp_busy0", ch_busy[0], (e < 12) ? 1 : 0);
    end
    chk("ramp_duty2_hold", duty_cycle_2, 50);
    chk("ramp_duty5_hold", duty_cycle_5, 50);
    chk("ramp_idle", all_idle, 1);

    // Broadcast clamp: accepted on edge 13; first step edge 16, 50th at 212.
    cmd_valid = 1'b1; cmd_ch = 3'd7; cmd_target = 7'd120;
    tick();
    cmd_valid = 1'b0;
    chk("bc_busy", ch_busy, 5'b11111);
    tick_n(3);
    chk("bc_duty1_first", duty_cycle_1, 54);
    chk("bc_duty2_first", duty_cycle_2, 51);
    tick_n(195);
    chk("bc_duty2_pre", duty_cycle_2, 99);
    chk("bc_idle_pre", all_idle, 0);
    chk("bc_duty1_done", duty_cycle_1, 100);
    tick();
    chk("bc_duty2", duty_cycle_2, 100);
    chk("bc_duty3", duty_cycle_3, 100);
    chk("bc_duty4", duty_cycle_4, 100);
    chk("bc_duty5", duty_cycle_5, 100);
    chk("bc_idle", all_idle, 1);

    // Sync backpressure from reset state.
    do_reset();
    sync_mode = 1'b1;
    cmd_valid = 1'b1; cmd_ch = 3'd1; cmd_target = 7'd48;
    tick();
    cmd_ch = 3'd2; cmd_target = 7'd60;
    chk("sync_ready_low", cmd_ready, 0);
    chk("sync_busy", ch_busy, 5'b00010);
    tick_n(6);
    chk("sync_duty2_mid", duty_cycle_2, 49);
    chk("sync_ready_still_low", cmd_ready, 0);
    chk("sync_duty3_wait", duty_cycle_3, 50);
    tick();
    chk("sync_duty2_done", duty_cycle_2, 48);
    chk("sync_idle", all_idle, 1);
    chk("sync_ready_high", cmd_ready, 1);
    chk("sync_busy_none", ch_busy, 0);
    tick();
    cmd_valid = 1'b0;
    chk("sync_ch2_accepted", ch_busy, 5'b00100);
    chk("sync_ready_low2", cmd_ready, 0);
    tick_n(39);
    chk("sync_duty3_done", duty_cycle_3, 60);
    chk("sync_idle2", all_idle, 1);
    sync_mode = 1'b0;

    // Retarget mid-ramp: accept at edge 49; steps on 52..80.
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_target = 7'd60;
    tick();
    cmd_valid = 1'b0;
    tick_n(2);
    chk("rt_duty1_start", duty_cycle_1, 50);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("rt_step", duty_cycle_1, seq[j]);
      if (j == 4) begin
        cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_target = 7'd52;
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        cmd_valid = 1'b0;
        chk("rt_hold", duty_cycle_1, seq[j]);
      end
    end
    chk("rt_busy_clear", ch_busy, 0);

    // Illegal channel: single, then back-to-back.
    cmd_valid = 1'b1; cmd_ch = 3'd5; cmd_target = 7'd10;
    tick();
    cmd_valid = 1'b0;
    chk("ill_err_pulse", cmd_err, 1);
    chk("ill_busy", ch_busy, 0);
    tick();
    chk("ill_err_clear", cmd_err, 0);
    cmd_valid = 1'b1; cmd_ch = 3'd6;
    tick();
    chk("ill_b2b_1", cmd_err, 1);
    tick();
    cmd_valid = 1'b0;
    chk("ill_b2b_2", cmd_err, 1);
    tick();
    chk("ill_b2b_clear", cmd_err, 0);
    chk("ill_duty1", duty_cycle_1, 52);
    chk("ill_duty2", duty_cycle_2, 48);
    chk("ill_duty3", duty_cycle_3, 60);
    chk("ill_duty4", duty_cycle_4, 50);

    // Async reset mid-ramp at 57: accept edge 89, reaches 57 on edge 108.
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_target = 7'd60;
    tick();
    cmd_valid = 1'b0;
    tick_n(19);
    chk("ar_duty1_57", duty_cycle_1, 57);
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_target = 7'd70;
    #1 reset = 1'b0;
    #1;
    chk("ar_duty1_snap", duty_cycle_1, 50);
    chk("ar_duty2_snap", duty_cycle_2, 50);
    chk("ar_duty3_snap", duty_cycle_3, 50);
    chk("ar_busy_snap", ch_busy, 0);
    @(negedge clk);
    tick_n(2);
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick_n(12);
    chk("ar_no_resume", duty_cycle_1, 50);
    chk("ar_idle", all_idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
